// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the fetch stage.
// States, default parameter values and offset helper.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_e;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_000D;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'd4;

  function automatic logic [31:0] sext_shl2(
    input logic [15:0] off
  );
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc.sv
// Next-PC selection: jr > jump > branch > sequential.
// Flags targets that are misaligned or past the end of memory.
module next_pc_calc
  import mips_fetch_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] next_pc,
  output logic        target_fault
);

  localparam logic [32:0] LIMIT = 33'(MEM_WORDS) * 33'd4;

  logic [31:0] pc4;

  // Priority target mux and range/alignment check
  always_comb begin
    pc4 = pc + PC_STEP;
    next_pc = pc4;
    if (jr)
      next_pc = jr_addr;
    else if (jump)
      next_pc = {pc4[31:28], jump_target, 2'b00};
    else if (branch_taken)
      next_pc = pc4 + sext_shl2(branch_offset);
    target_fault = (next_pc[1:0] != 2'b00) ||
                   ({1'b0, next_pc} >= LIMIT);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, fetch register, BOOT/RUN/HALT FSM.
// Optional perf counters enabled by FETCH_PERF_CNT_EN.
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned MEM_WORDS = 32,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic        fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  fetch_state_e state, state_d;

  logic [31:0] pc_d, instr_d, ipc_d;
  logic        valid_d, halted_d, fault_d;
  logic [31:0] next_pc;
  logic        target_fault;

  next_pc_calc #(
    .MEM_WORDS(MEM_WORDS)
  ) u_next_pc (
    .pc           (pc),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .next_pc      (next_pc),
    .target_fault (target_fault)
  );

  // Next-state and register-update decisions
  always_comb begin
    state_d  = state;
    pc_d     = pc;
    instr_d  = instr_out;
    ipc_d    = instr_pc;
    valid_d  = instr_valid;
    halted_d = halted;
    fault_d  = fault;
    unique case (state)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b0;
      end
      RUN: begin
        if (!stall) begin
          instr_d = instruction;
          ipc_d   = pc;
          valid_d = 1'b1;
          if (target_fault) begin
            fault_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = HALT;
          end else if (instruction == HALT_WORD) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: state_d = BOOT;
    endcase
  end

  // State and fetch registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instr_out   <= instr_d;
      instr_pc    <= ipc_d;
      instr_valid <= valid_d;
      halted      <= halted_d;
      fault       <= fault_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic capture;
  logic run_stall;

  assign capture   = (state == RUN) && !stall;
  assign run_stall = (state == RUN) && stall;

  // Saturating fetch and stall counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (capture && (fetch_count != '1))
        fetch_count <= fetch_count + 32'd1;
      if (run_stall && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed vector table,
// hand sequences for halt, then randomized model check.
module tb_pc_fetch_unit;

  localparam int MW = 32;
  localparam logic [31:0] HW = 32'h0000_000D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        halted;
  logic        fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic [31:0] mem [MW];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign instruction = (pc < 32'(MW * 4)) ? mem[pc[6:2]] : 32'h0;

  pc_fetch_unit #(
    .RESET_PC (32'h0),
    .MEM_WORDS(MW),
    .HALT_WORD(HW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .instruction  (instruction),
    .pc           (pc),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .halted       (halted),
    .fault        (fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
`endif
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] off;
    logic        j;
    logic [25:0] jt;
    logic        jr;
    logic [31:0] ja;
    logic [31:0] epc;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] eipc;
    logic        eh;
    logic        ef;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h",
               nm, tag, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rs, input logic st,
    input logic br, input logic [15:0] off,
    input logic j, input logic [25:0] jt,
    input logic r, input logic [31:0] ja,
    input logic [31:0] epc, input logic ev,
    input logic [31:0] ei, input logic [31:0] eipc,
    input logic eh, input logic ef);
    vec_t v;
    v.rst = rs; v.stall = st; v.br = br; v.off = off;
    v.j = j; v.jt = jt; v.jr = r; v.ja = ja;
    v.epc = epc; v.ev = ev; v.ei = ei; v.eipc = eipc;
    v.eh = eh; v.ef = ef;
    return v;
  endfunction

  // rst=1 means run (rst_n high); rst=0 applies reset
  function automatic vec_t rs();
    return mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
  endfunction
  function automatic vec_t bt();
    return mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0);
  endfunction
  function automatic vec_t sq(input logic [31:0] epc,
                              input logic [31:0] ei,
                              input logic [31:0] eipc);
    return mk(1,0,0,0,0,0,0,0, epc,1,ei,eipc,0,0);
  endfunction

  task automatic run_vec(input vec_t v, input int tag);
    rst_n = v.rst; stall = v.stall;
    branch_taken = v.br; branch_offset = v.off;
    jump = v.j; jump_target = v.jt;
    jr = v.jr; jr_addr = v.ja;
    @(posedge clk);
    #1;
    chk("pc", tag, pc, v.epc);
    chk("instr_valid", tag, 32'(instr_valid), 32'(v.ev));
    chk("instr_out", tag, instr_out, v.ei);
    chk("instr_pc", tag, instr_pc, v.eipc);
    chk("halted", tag, 32'(halted), 32'(v.eh));
    chk("fault", tag, 32'(fault), 32'(v.ef));
  endtask

  // Behavioural reference state
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_valid, m_halt, m_fault, m_boot;
  longint      m_fc, m_sc;

  task automatic model_edge();
    longint p4, t, off;
    logic [31:0] w;
    if (!rst_n) begin
      m_pc = 0; m_instr = 0; m_ipc = 0;
      m_valid = 0; m_halt = 0; m_fault = 0;
      m_boot = 1; m_fc = 0; m_sc = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      m_valid = 0;
    end else if (stall) begin
      if (m_sc < 64'hFFFF_FFFF) m_sc++;
    end else begin
      w = mem[m_pc[6:2]];
      m_instr = w; m_ipc = m_pc; m_valid = 1;
      if (m_fc < 64'hFFFF_FFFF) m_fc++;
      p4 = (longint'(m_pc) + 4) % 64'h1_0000_0000;
      off = longint'($signed(branch_offset));
      if (jr)
        t = longint'(jr_addr);
      else if (jump)
        t = (p4 / (64'd1 << 28)) * (64'd1 << 28)
            + longint'(jump_target) * 4;
      else if (branch_taken)
        t = (p4 + off * 4 + 64'h1_0000_0000)
            % 64'h1_0000_0000;
      else
        t = p4;
      if ((t % 4) != 0 || t >= MW * 4) begin
        m_fault = 1; m_halt = 1;
      end else if (w == HW) begin
        m_halt = 1;
      end else begin
        m_pc = 32'(t);
      end
    end
  endtask

  initial begin
    rst_n = 0; stall = 0; branch_taken = 0;
    branch_offset = 0; jump = 0; jump_target = 0;
    jr = 0; jr_addr = 0;
    for (int i = 0; i < MW; i++) mem[i] = 32'h0;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'hAC0A_0004;
    mem[4] = 32'h8C0B_0004;

    // sequential fetch after boot
    tbl.push_back(rs());
    tbl.push_back(bt());
    tbl.push_back(sq(4,  32'h2008_0005, 0));
    tbl.push_back(sq(8,  32'h2009_0003, 4));
    tbl.push_back(sq(12, 32'h0109_5020, 8));
    tbl.push_back(sq(16, 32'hAC0A_0004, 12));
    // stall at pc=8 with a jump that must be ignored
    tbl.push_back(rs());
    tbl.push_back(bt());
    tbl.push_back(sq(4, 32'h2008_0005, 0));
    tbl.push_back(sq(8, 32'h2009_0003, 4));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,1,0,0,1,5,0,0,
                       8,1,32'h2009_0003,4,0,0));
    tbl.push_back(sq(12, 32'h0109_5020, 8));
    // forward and backward branch
    tbl.push_back(rs());
    tbl.push_back(bt());
    tbl.push_back(sq(4, 32'h2008_0005, 0));
    tbl.push_back(mk(1,0,1,16'h0002,0,0,0,0,
                     16,1,32'h2009_0003,4,0,0));
    tbl.push_back(mk(1,0,1,16'hFFFC,0,0,0,0,
                     4,1,32'h8C0B_0004,16,0,0));
    // priority jr > jump > branch, then plain jump
    tbl.push_back(rs());
    tbl.push_back(bt());
    tbl.push_back(mk(1,0,1,16'h0001,1,2,1,32'h1C,
                     32'h1C,1,32'h2008_0005,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,3,0,0,
                     32'hC,1,0,32'h1C,0,0));
    tbl.push_back(sq(32'h10, 32'hAC0A_0004, 32'hC));
    // misaligned jr, HALT ignores redirects, reset
    tbl.push_back(rs());
    tbl.push_back(bt());
    tbl.push_back(sq(4, 32'h2008_0005, 0));
    tbl.push_back(mk(1,0,0,0,0,0,1,32'h6,
                     4,1,32'h2009_0003,4,1,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,
                     4,0,32'h2009_0003,4,1,1));
    tbl.push_back(mk(1,0,0,0,1,0,1,32'h8,
                     4,0,32'h2009_0003,4,1,1));
    tbl.push_back(rs());
    tbl.push_back(bt());
    // out-of-range jr
    tbl.push_back(mk(1,0,0,0,0,0,1,32'h80,
                     0,1,32'h2008_0005,0,1,1));
    tbl.push_back(rs());
    // sequential step past the last word
    tbl.push_back(bt());
    tbl.push_back(mk(1,0,0,0,0,0,1,32'h7C,
                     32'h7C,1,32'h2008_0005,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,
                     32'h7C,1,0,32'h7C,1,1));

    for (int i = 0; i < tbl.size(); i++)
      run_vec(tbl[i], i);

    // halt word at address 8
    mem[2] = HW;
    run_vec(rs(), 100);
    run_vec(bt(), 101);
    run_vec(sq(4, 32'h2008_0005, 0), 102);
    run_vec(sq(8, 32'h2009_0003, 4), 103);
    run_vec(mk(1,0,0,0,0,0,0,0, 8,1,HW,8,1,0), 104);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", 104, fetch_count, 32'd3);
    chk("stall_count", 104, stall_count, 32'd0);
`endif
    run_vec(mk(1,0,0,0,0,0,0,0, 8,0,HW,8,1,0), 105);
    run_vec(mk(1,0,0,0,0,0,0,0, 8,0,HW,8,1,0), 106);

    // halt word together with a faulting target
    run_vec(rs(), 110);
    run_vec(bt(), 111);
    run_vec(sq(4, 32'h2008_0005, 0), 112);
    run_vec(sq(8, 32'h2009_0003, 4), 113);
    run_vec(mk(1,0,0,0,0,0,1,32'h6, 8,1,HW,8,1,1), 114);

    // randomized run against the reference model
    for (int i = 0; i < MW; i++)
      mem[i] = ($urandom_range(0, 29) == 0) ? HW : $urandom;
    rst_n = 0;
    model_edge();
    @(posedge clk);
    #1;
    for (int k = 0; k < 800; k++) begin
      rst_n = !((k % 50) == 49 ||
                $urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      branch_offset = 16'($urandom_range(0, 20)) - 16'd10;
      jump = ($urandom_range(0, 9) == 0);
      jump_target = 26'($urandom_range(0, 40));
      jr = ($urandom_range(0, 14) == 0);
      jr_addr = 32'($urandom_range(0, 140));
      model_edge();
      @(posedge clk);
      #1;
      chk("rnd_pc", k, pc, m_pc);
      chk("rnd_valid", k, 32'(instr_valid), 32'(m_valid));
      chk("rnd_instr", k, instr_out, m_instr);
      chk("rnd_ipc", k, instr_pc, m_ipc);
      chk("rnd_halted", k, 32'(halted), 32'(m_halt));
      chk("rnd_fault", k, 32'(fault), 32'(m_fault));
`ifdef FETCH_PERF_CNT_EN
      chk("rnd_fcnt", k, fetch_count, 32'(m_fc));
      chk("rnd_scnt", k, stall_count, 32'(m_sc));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
